// File: rtl/led_blink_mc_if.sv
// led_blink_mc_if: FPro MMIO slot bus between a bus master and the LED blink core.
interface led_blink_mc_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] rd_data;
  logic [31:0] wr_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/led_blink_mc_core.sv
// led_blink_mc_core: multi-channel LED blinker (off/on/blink/one-shot) on an FPro MMIO slot.
// Optional macro LED_BLINK_SYNC_EN builds the CTRL.sync phase-alignment strobe.
module led_blink_mc_core #(
  parameter int N_CH     = 16,
  parameter int PRESCALE = 100000,
  parameter int HP_W     = 16
) (
  input  logic            clk,
  input  logic            reset,
  led_blink_mc_if.slave   bus,
  output logic [N_CH-1:0] led
);
  localparam int PW = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  logic            en_q, en_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [N_CH-1:0] st_q, st_d;
  logic [HP_W-1:0] hp_q   [N_CH];
  logic [HP_W-1:0] hp_d   [N_CH];
  logic [HP_W-1:0] ccnt_q [N_CH];
  logic [HP_W-1:0] ccnt_d [N_CH];
  mode_e           mode_q [N_CH];
  mode_e           mode_d [N_CH];

  logic        wr_en;
  logic        tick;
  logic        sync;
  logic [31:0] rd_word;
  logic        unused_bus;

  // A zero half-period behaves as one tick, so the terminal count is 0.
  function automatic logic [HP_W-1:0] last_cnt(input logic [HP_W-1:0] hp);
    return (hp == '0) ? '0 : hp - 1'b1;
  endfunction

  assign unused_bus = ^{bus.read, bus.wr_data};

  always_comb begin
    en_d   = en_q;
    pcnt_d = pcnt_q;
    st_d   = st_q;
    hp_d   = hp_q;
    ccnt_d = ccnt_q;
    mode_d = mode_q;
    wr_en  = bus.cs & bus.write;
    tick   = en_q && (pcnt_q == PW'(PRESCALE - 1));
    sync   = 1'b0;

    if (en_q) pcnt_d = tick ? '0 : pcnt_q + 1'b1;

    if (wr_en && bus.addr == 5'h00) begin
      en_d = bus.wr_data[0];
`ifdef LED_BLINK_SYNC_EN
      sync = bus.wr_data[1];
`endif
    end
    if (sync) pcnt_d = '0;

    for (int i = 0; i < N_CH; i++) begin
      case (mode_q[i])
        MODE_OFF: begin
          st_d[i]   = 1'b0;
          ccnt_d[i] = '0;
        end
        MODE_ON: begin
          st_d[i]   = 1'b1;
          ccnt_d[i] = '0;
        end
        default: begin
          if (sync) begin
            st_d[i]   = 1'b1;
            ccnt_d[i] = '0;
          end else if (tick) begin
            if (ccnt_q[i] == last_cnt(hp_q[i])) begin
              ccnt_d[i] = '0;
              if (mode_q[i] == MODE_BLINK) begin
                st_d[i] = ~st_q[i];
              end else begin
                st_d[i]   = 1'b0;
                mode_d[i] = MODE_OFF;
              end
            end else begin
              ccnt_d[i] = ccnt_q[i] + 1'b1;
            end
          end
        end
      endcase

      // A channel write overrides any tick landing on the same edge.
      if (wr_en && bus.addr == 5'(16 + i)) begin
        hp_d[i]   = bus.wr_data[HP_W-1:0];
        mode_d[i] = mode_e'(bus.wr_data[17:16]);
        ccnt_d[i] = '0;
        st_d[i]   = (bus.wr_data[17:16] != 2'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q   <= 1'b0;
      pcnt_q <= '0;
      st_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hp_q[i]   <= '0;
        ccnt_q[i] <= '0;
        mode_q[i] <= MODE_OFF;
      end
    end else begin
      en_q   <= en_d;
      pcnt_q <= pcnt_d;
      st_q   <= st_d;
      hp_q   <= hp_d;
      ccnt_q <= ccnt_d;
      mode_q <= mode_d;
    end
  end

  assign led = en_q ? st_q : '0;

  always_comb begin
    rd_word = '0;
    if (bus.addr == 5'h00) rd_word[0] = en_q;
    else if (bus.addr == 5'h01) rd_word[N_CH-1:0] = led;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.addr == 5'(16 + i)) begin
        rd_word[HP_W-1:0] = hp_q[i];
        rd_word[17:16]    = mode_q[i];
      end
    end
    bus.rd_data = rd_word;
  end
endmodule

// File: tb/tb_led_blink_mc_core.sv
// Self-checking bench for led_blink_mc_core: tick-count reference model plus directed scenarios.
module tb_led_blink_mc_core;
  localparam int P = 4;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] led;
  led_blink_mc_if bus ();

  led_blink_mc_core #(.N_CH(N), .PRESCALE(P), .HP_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .led   (led)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // Reference model: enabled-cycle count drives ticks; each channel counts ticks since load.
  bit          m_en;
  int          m_ecnt;
  logic [15:0] m_hp   [N];
  int          m_mode [N];
  int          m_k    [N];

  function automatic int hpe(input int i);
    return (m_hp[i] == 16'd0) ? 1 : int'(m_hp[i]);
  endfunction

  function automatic logic [3:0] exp_led();
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      case (m_mode[i])
        1: r[i] = 1'b1;
        2: r[i] = ((m_k[i] / hpe(i)) % 2) == 0;
        3: r[i] = 1'b1;
        default: r[i] = 1'b0;
      endcase
    end
    return m_en ? r : 4'b0000;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] r;
    int ch;
    r  = '0;
    ch = int'(a) - 16;
    if (a == 5'd0) r[0] = m_en;
    else if (a == 5'd1) r[3:0] = exp_led();
    else if (ch >= 0 && ch < N) begin
      r[15:0]  = m_hp[ch];
      r[17:16] = 2'(m_mode[ch]);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset === 1'b0) begin
      m_en   = 1'b0;
      m_ecnt = 0;
      for (int i = 0; i < N; i++) begin
        m_hp[i] = '0; m_mode[i] = 0; m_k[i] = 0;
      end
    end else begin
      bit tk, wr, sy;
      tk = m_en && (m_ecnt % P == P - 1);
      wr = bus.cs && bus.write;
      sy = 1'b0;
`ifdef LED_BLINK_SYNC_EN
      sy = wr && bus.addr == 5'd0 && bus.wr_data[1];
`endif
      if (m_en) m_ecnt++;
      if (sy) m_ecnt = 0;
      for (int i = 0; i < N; i++) begin
        if (m_mode[i] >= 2) begin
          if (sy) m_k[i] = 0;
          else if (tk) begin
            m_k[i]++;
            if (m_mode[i] == 3 && m_k[i] >= hpe(i)) begin
              m_mode[i] = 0;
              m_k[i]    = 0;
            end
          end
        end
      end
      if (wr && bus.addr == 5'd0) m_en = bus.wr_data[0];
      for (int i = 0; i < N; i++) begin
        if (wr && int'(bus.addr) == 16 + i) begin
          m_hp[i]   = bus.wr_data[15:0];
          m_mode[i] = int'(bus.wr_data[17:16]);
          m_k[i]    = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_tests++;
      if (led !== exp_led()) begin
        n_fail++;
        $display("FAIL led_cycle t=%0t: got %b expected %b", $time, led, exp_led());
      end
      n_tests++;
      if (bus.rd_data !== exp_rd(bus.addr)) begin
        n_fail++;
        $display("FAIL rd_cycle t=%0t addr=%h: got %h expected %h", $time, bus.addr,
                 bus.rd_data, exp_rd(bus.addr));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    @(negedge clk); #1;
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    bus.addr = a;
    bus.read = 1'b1;
    #1;
    chk(nm, bus.rd_data, exp);
    bus.read = 1'b0;
  endtask

  task automatic wait_led(input int b, input logic v, input int maxc, output int cnt);
    cnt = 0;
    while (led[b] !== v && cnt < maxc) begin
      @(negedge clk); #1;
      cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, c2, t0, t1;
    logic [31:0] d;
    logic [4:0]  a;
    reset = 1'b0; bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.addr = '0; bus.wr_data = '0;
    repeat (2) begin @(negedge clk); #1; end
    chk_on = 1'b1;
    reset  = 1'b1;
    idle(1);
    chk("reset_led", {28'd0, led}, 32'd0);
    rd_chk("reset_ctrl", 5'h00, 32'd0);
    rd_chk("reset_status", 5'h01, 32'd0);
    rd_chk("reset_ch0", 5'h10, 32'd0);

    wr_reg(5'h00, 32'h1);
    wr_reg(5'h10, 32'h0002_0003);
    chk("blink_on", {31'd0, led[0]}, 32'd1);
    bus.addr = 5'h01;
    wait_led(0, 1'b0, 40, c);
    chk("blink_first_in_9_15", {31'd0, (c >= 9 && c <= 15)}, 32'd1);
    wait_led(0, 1'b1, 40, c2);
    chk("blink_period_hi", c2, 32'd12);
    wait_led(0, 1'b0, 40, c2);
    chk("blink_period_lo", c2, 32'd12);
    rd_chk("ch0_readback", 5'h10, 32'h0002_0003);

    wr_reg(5'h11, 32'h0003_0000);
    chk("oneshot_on", {31'd0, led[1]}, 32'd1);
    wait_led(1, 1'b0, 20, c);
    chk("oneshot_len_1_4", {31'd0, (c >= 1 && c <= 4)}, 32'd1);
    idle(2);
    rd_chk("oneshot_mode_cleared", 5'h11, 32'd0);

    wr_reg(5'h12, 32'h0002_0005);
    idle(17);
    wr_reg(5'h00, 32'h0);
    t0 = 0;
    for (int i = 0; i < 50; i++) begin
      if (led !== 4'b0000) t0++;
      idle(1);
    end
    chk("freeze_led_zero_cycles", t0, 32'd0);
    wr_reg(5'h00, 32'h1);
    idle(60);

    c = 0;
    while (!(m_en && (m_ecnt % P == P - 1)) && c < 16) begin idle(1); c++; end
    chk("collision_found_tick", {31'd0, (c < 16)}, 32'd1);
    wr_reg(5'h13, 32'h0002_0002);
    chk("collision_led3", {31'd0, led[3]}, 32'd1);
    wait_led(3, 1'b0, 30, c);
    chk("collision_first_toggle", c, 32'd8);

`ifdef LED_BLINK_SYNC_EN
    wr_reg(5'h10, 32'h0002_0003);
    wr_reg(5'h11, 32'h0002_0005);
    idle(37);
    wr_reg(5'h00, 32'h3);
    chk("sync_both_on", {30'd0, led[1:0]}, 32'd3);
    t0 = 0; t1 = 0;
    for (int i = 1; i <= 30; i++) begin
      idle(1);
      if (t0 == 0 && led[0] == 1'b0) t0 = i;
      if (t1 == 0 && led[1] == 1'b0) t1 = i;
    end
    chk("sync_ch0_toggle", t0, 32'd12);
    chk("sync_ch1_toggle", t1, 32'd20);
`else
    wr_reg(5'h00, 32'h3);
    idle(5);
`endif
    rd_chk("ctrl_sync_reads_0", 5'h00, 32'd1);

    for (int it = 0; it < 3000; it++) begin
      c = $urandom_range(0, 99);
      if (c < 2) begin
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
      end else if (c < 32) begin
        case ($urandom_range(0, 7))
          0, 1: a = 5'h00;
          2:    a = 5'h01;
          3:    a = 5'($urandom_range(0, 31));
          default: a = 5'(16 + $urandom_range(0, N - 1));
        endcase
        d = $urandom;
        if (a == 5'h00) d[0] = ($urandom_range(0, 3) != 0);
        else if ($urandom_range(0, 3) != 0) d[15:0] = 16'($urandom_range(0, 4));
        wr_reg(a, d);
      end else begin
        bus.addr = 5'($urandom_range(0, 31));
        idle(1);
      end
    end
    idle(5);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
